// File: rtl/tpiu_frame_decoder.sv
// TPIU frame decoder: captures 16-byte trace frames handed over by the trace-clock side
// and unpacks them into a registered valid/ready stream of (stream ID, byte) pairs.
module tpiu_frame_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter bit DROP_NULL   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] Packet,
  input  logic         PkAvail,
  output logic         PkAck,
  input  logic         sync,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [6:0]   out_id,
  output logic [7:0]   out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Cross-domain inputs.
  logic [SYNC_STAGES-1:0] avail_sync_q;
  logic [SYNC_STAGES-1:0] insync_sync_q;
  logic                   avail_prev_q;
  logic                   pending_q;
  logic                   avail_s;
  logic                   insync_s;
  logic                   avail_rise;

  // Frame walk state and registered outputs.
  state_t       state_q;
  logic [127:0] frame_q;
  logic [3:0]   slot_q;
  logic [6:0]   cur_id_q;
  logic [6:0]   defer_id_q;
  logic         defer_vld_q;
  logic         ack_q;
  logic         busy_q;
  logic         out_valid_q;
  logic [6:0]   out_id_q;
  logic [7:0]   out_data_q;

  // Slot decode.
  logic [7:0] slot_byte;
  logic [2:0] slot_k;
  logic       slot_aux;
  logic       slot_odd;
  logic       id_emit_ok;
  logic       slot_emits;
  logic [7:0] emit_data;
  logic       advance;

  assign avail_s    = avail_sync_q[SYNC_STAGES-1];
  assign insync_s   = insync_sync_q[SYNC_STAGES-1];
  assign avail_rise = avail_s & ~avail_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail_sync_q  <= '0;
      insync_sync_q <= '0;
      avail_prev_q  <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      avail_sync_q  <= {avail_sync_q[SYNC_STAGES-2:0], PkAvail};
      insync_sync_q <= {insync_sync_q[SYNC_STAGES-2:0], sync};
      avail_prev_q  <= avail_s;
      // A second edge while one frame is already pending is simply absorbed.
      pending_q     <= avail_rise | (pending_q & (state_q != IDLE));
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    slot_byte  = frame_q[{slot_q, 3'b000} +: 8];
    slot_k     = slot_q[3:1];
    slot_aux   = frame_q[120 + {29'd0, slot_k}];
    slot_odd   = slot_q[0];
    id_emit_ok = !(DROP_NULL && ((cur_id_q == 7'h00) || (cur_id_q == 7'h7F)));
    emit_data  = slot_odd ? slot_byte : {slot_byte[7:1], slot_aux};
    slot_emits = id_emit_ok && (slot_odd || !slot_byte[0]);
    advance    = !out_valid_q || out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      slot_q      <= '0;
      cur_id_q    <= '0;
      defer_id_q  <= '0;
      defer_vld_q <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            frame_q     <= Packet;
            ack_q       <= 1'b1;
            slot_q      <= '0;
            defer_vld_q <= 1'b0;
            if (insync_s) begin
              busy_q  <= 1'b1;
              state_q <= EMIT;
            end else begin
              cur_id_q <= '0;
            end
          end
        end

        EMIT: begin
          // Nothing moves while a presented byte is still waiting for the consumer.
          if (advance) begin
            out_valid_q <= 1'b0;
            if (slot_emits) begin
              out_valid_q <= 1'b1;
              out_id_q    <= cur_id_q;
              out_data_q  <= emit_data;
            end
            if (slot_odd) begin
              if (defer_vld_q) begin
                cur_id_q    <= defer_id_q;
                defer_vld_q <= 1'b0;
              end
            end else if (slot_byte[0]) begin
              if (!slot_aux || (slot_k == 3'd7)) begin
                cur_id_q <= slot_byte[7:1];
              end else begin
                defer_id_q  <= slot_byte[7:1];
                defer_vld_q <= 1'b1;
              end
            end
            if (slot_q == 4'd14) begin
              if (slot_emits) begin
                state_q <= DRAIN;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              slot_q <= slot_q + 4'd1;
            end
          end
        end

        DRAIN: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign PkAck     = ack_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;

endmodule
